// File: rtl/qspi_target_if.sv
// Register-file side of the quad-SPI target: a strobed, byte-lane access bus.
// The target drives address/data/strobes; the register file returns read data.
interface qspi_target_if #(
    parameter int AWIDTH = 8
);
    logic [AWIDTH-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic [3:0]        reg_be;
    logic              reg_we;
    logic              reg_re;
    logic [31:0]       reg_rdata;

    modport master (output reg_addr, reg_wdata, reg_be, reg_we, reg_re, input reg_rdata);
    modport slave  (input reg_addr, reg_wdata, reg_be, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/qspi_target.sv
// Quad-SPI target: decodes command/address/data frames from the pads and issues
// single-cycle register-file strobes in the clk domain; read data returns on CIPO.
//
// state | meaning
// IDLE  | waiting for CS_N to fall
// CMD   | shifting in the command byte
// ADDR  | shifting in the address byte, frame validated on its last nibble
// WDATA | shifting in 2N write-data nibbles
// RTURN | dummy byte while read data is fetched, CIPO driven 0
// RDATA | driving 2N read-data nibbles, one per SCK fall
// DRAIN | frame done or rejected, SCK ignored until CS_N rises
module qspi_target #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CS_N,
    input  logic          SCK,
    input  logic [3:0]    COPI,
    output logic [3:0]    CIPO,
    output logic          cipo_oe,
    output logic          frame_err,
    qspi_target_if.master bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RTURN, RDATA, DRAIN} state_t;
    state_t state, state_nxt;

    logic [1:0]      cs_sync, sck_sync;
    logic [1:0][3:0] copi_sync;
    logic            cs_q, sck_q;
    logic            cs_s, sck_s;
    logic [3:0]      copi_s;
    logic            cs_fall, sck_rise, sck_fall;

    logic [7:0]        cmd, addr, addr_in;
    logic [3:0]        cnt, last_nib;
    logic [DWIDTH-1:0] shreg, wsh_in;
    logic [1:0]        size;
    logic [2:0]        rd_shift;
    logic              re_d, frame_ok;
    logic              do_write, do_read, bad;

    function automatic logic [7:0] align(input logic [7:0] a, input logic [1:0] sz);
        case (sz)
            2'd1:    return {a[7:1], 1'b0};
            2'd2:    return {a[7:2], 2'b00};
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] lanes(input logic [1:0] lane, input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'b0001 << lane;
            2'd1:    return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    assign cs_s     = cs_sync[1];
    assign sck_s    = sck_sync[1];
    assign copi_s   = copi_sync[1];
    assign cs_fall  = !cs_s && cs_q;
    assign sck_rise = sck_s && !sck_q;
    assign sck_fall = !sck_s && sck_q;

    assign size     = cmd[1:0];
    assign addr_in  = {addr[3:0], copi_s};
    assign wsh_in   = {shreg[DWIDTH-5:0], copi_s};
    assign last_nib = (4'd2 << size) - 4'd1;
    // selected read lanes are moved to the top so they shift out MSB first
    assign rd_shift = 3'd4 - (3'd1 << size) - {1'b0, addr[1:0]};
    assign frame_ok = (cmd[6:2] == 5'd0) && (size != 2'd3) &&
                      !(size == 2'd1 && addr_in[0]) &&
                      !(size == 2'd2 && addr_in[1:0] != 2'd0);
    assign cipo_oe  = (state == RTURN) || (state == RDATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        do_read   = 1'b0;
        bad       = 1'b0;
        if (state != IDLE && cs_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (cs_fall) state_nxt = CMD;
                CMD:   if (sck_rise && cnt == 4'd1) state_nxt = ADDR;
                ADDR:  if (sck_rise && cnt == 4'd1) begin
                           if (!frame_ok) begin
                               bad       = 1'b1;
                               state_nxt = DRAIN;
                           end else if (cmd[7]) begin
                               do_read   = 1'b1;
                               state_nxt = RTURN;
                           end else begin
                               state_nxt = WDATA;
                           end
                       end
                WDATA: if (sck_rise && cnt == last_nib) begin
                           do_write  = 1'b1;
                           state_nxt = DRAIN;
                       end
                RTURN: if (sck_fall && cnt == 4'd2) state_nxt = RDATA;
                RDATA: if (sck_fall && cnt == last_nib) state_nxt = DRAIN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            copi_sync <= '0;
            cs_q      <= 1'b0;
            sck_q     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], CS_N};
            sck_sync  <= {sck_sync[0], SCK};
            copi_sync <= {copi_sync[0], COPI};
            cs_q      <= cs_s;
            sck_q     <= sck_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd           <= '0;
            addr          <= '0;
            cnt           <= '0;
            shreg         <= '0;
            re_d          <= 1'b0;
            CIPO          <= '0;
            frame_err     <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_be    <= '0;
            bus.reg_we    <= 1'b0;
            bus.reg_re    <= 1'b0;
        end else begin
            bus.reg_we <= do_write;
            bus.reg_re <= do_read;
            frame_err  <= bad;
            re_d       <= bus.reg_re;

            if (state_nxt != state)
                cnt <= '0;
            else if (sck_rise && (state == CMD || state == ADDR || state == WDATA || state == RTURN))
                cnt <= cnt + 4'd1;
            else if (sck_fall && state == RDATA)
                cnt <= cnt + 4'd1;

            if (state == CMD && sck_rise)   cmd   <= {cmd[3:0], copi_s};
            if (state == ADDR && sck_rise)  addr  <= addr_in;
            if (state == WDATA && sck_rise) shreg <= wsh_in;
            if (re_d)                       shreg <= bus.reg_rdata << {rd_shift, 3'b000};

            if (do_write) begin
                bus.reg_addr  <= AWIDTH'(align(addr, size));
                bus.reg_be    <= lanes(addr[1:0], size);
                bus.reg_wdata <= wsh_in << {addr[1:0], 3'b000};
            end
            if (do_read) begin
                bus.reg_addr <= AWIDTH'(align(addr_in, size));
                bus.reg_be   <= lanes(addr_in[1:0], size);
            end

            if ((state == RTURN && state_nxt == RDATA) ||
                (state == RDATA && state_nxt == RDATA && sck_fall)) begin
                CIPO  <= shreg[DWIDTH-1 -: 4];
                shreg <= shreg << 4;
            end else if (state_nxt != RDATA) begin
                CIPO <= '0;
            end

            if (state == IDLE && state_nxt == CMD) shreg <= '0;
        end
    end
endmodule

// File: tb/tb_qspi_target.sv
// Bench for qspi_target: drives quad-SPI frames, models the register file and
// scoreboards register strobes and CIPO nibbles against expected queues.
module tb_qspi_target;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       CS_N  = 1'b1;
    logic       SCK   = 1'b0;
    logic [3:0] COPI  = 4'h0;
    logic [3:0] CIPO;
    logic       cipo_oe;
    logic       frame_err;

    qspi_target_if #(.AWIDTH(8)) bus ();

    qspi_target #(.AWIDTH(8), .DWIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CS_N      (CS_N),
        .SCK       (SCK),
        .COPI      (COPI),
        .CIPO      (CIPO),
        .cipo_oe   (cipo_oe),
        .frame_err (frame_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    wr_t         wq[$];
    logic [7:0]  rq[$];
    logic [3:0]  nq[$];
    wr_t         w;
    logic [31:0] rd_value = '0;
    int n_cmp = 0, n_bad = 0;
    int we_seen = 0, re_seen = 0, err_seen = 0, both_seen = 0;
    int exp_we = 0, exp_re = 0, exp_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // register file: read data valid the cycle after reg_re
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bus.reg_rdata <= '0;
        else if (bus.reg_re) bus.reg_rdata <= rd_value;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.reg_we) begin
                we_seen++;
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    check("we_addr", bus.reg_addr, w.addr);
                    check("we_wdata", bus.reg_wdata, w.wdata);
                    check("we_be", bus.reg_be, w.be);
                end
            end
            if (bus.reg_re) begin
                re_seen++;
                if (rq.size() > 0) check("re_addr", bus.reg_addr, rq.pop_front());
            end
            if (frame_err) err_seen++;
            if (bus.reg_we && bus.reg_re) both_seen++;
        end
    end

    task automatic nib(input logic [3:0] n);
        COPI = n;
        #60 SCK = 1'b1;
        #60 SCK = 1'b0;
    endtask

    task automatic nib_rd();
        logic [3:0] e;
        COPI = 4'h0;
        #60;
        e = (nq.size() > 0) ? nq.pop_front() : 4'hx;
        check("cipo", CIPO, e);
        check("cipo_oe_rd", cipo_oe, 1);
        SCK = 1'b1;
        #60 SCK = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        nib(b[7:4]);
        nib(b[3:0]);
    endtask

    task automatic cs_start();
        CS_N = 1'b0;
        #60;
    endtask

    task automatic cs_end();
        #60 CS_N = 1'b1;
        #80;
    endtask

    task automatic wr_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d, input int nn);
        cs_start();
        send_byte(c);
        send_byte(a);
        for (int i = nn - 1; i >= 0; i--) nib(d[i*4 +: 4]);
        cs_end();
    endtask

    task automatic rd_frame(input logic [7:0] c, input logic [7:0] a, input int nn);
        cs_start();
        send_byte(c);
        send_byte(a);
        for (int i = 0; i < nn + 2; i++) nib_rd();
        cs_end();
        check("cipo_oe_after", cipo_oe, 0);
    endtask

    task automatic exp_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        w.addr  = a;
        w.wdata = d;
        w.be    = be;
        wq.push_back(w);
        exp_we++;
    endtask

    task automatic exp_read(input logic [7:0] a, input logic [31:0] rd, input logic [31:0] d, input int nn);
        rd_value = rd;
        rq.push_back(a);
        exp_re++;
        nq.push_back(4'h0);
        nq.push_back(4'h0);
        for (int i = nn - 1; i >= 0; i--) nq.push_back(d[i*4 +: 4]);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_we"}, we_seen, exp_we);
        check({tag, "_re"}, re_seen, exp_re);
        check({tag, "_err"}, err_seen, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #32;
        check("rst_cipo", CIPO, 0);
        check("rst_oe", cipo_oe, 0);
        check("rst_we", bus.reg_we, 0);
        check("rst_re", bus.reg_re, 0);
        check("rst_addr", bus.reg_addr, 0);
        check("rst_wdata", bus.reg_wdata, 0);
        check("rst_be", bus.reg_be, 0);
        check("rst_err", frame_err, 0);
        rst_n = 1'b1;
        #50;

        exp_write(8'd12, 32'h0000000B, 4'b0011);
        wr_frame(8'h01, 8'd12, 32'h000B, 4);
        check_counts("hw12");

        exp_write(8'd14, 32'h03150000, 4'b1100);
        wr_frame(8'h01, 8'd14, 32'h0315, 4);

        exp_write(8'd112, 32'h00AAAAAA, 4'b1111);
        wr_frame(8'h02, 8'd112, 32'h00AAAAAA, 8);
        exp_read(8'd112, 32'h00AAAAAA, 32'h00AAAAAA, 8);
        rd_frame(8'h82, 8'd112, 8);
        check_counts("word");

        exp_read(8'd0, 32'h00000055, 32'h55, 2);
        rd_frame(8'h80, 8'd0, 2);
        exp_read(8'd3, 32'h77000000, 32'h77, 2);
        rd_frame(8'h80, 8'd3, 2);
        exp_read(8'd2, 32'h12345678, 32'h1234, 4);
        rd_frame(8'h81, 8'd2, 4);
        check_counts("reads");

        // misaligned halfword write: extra data nibbles land in DRAIN
        exp_err++;
        cs_start();
        send_byte(8'h01);
        send_byte(8'd13);
        for (int i = 0; i < 4; i++) nib(4'hF);
        check("drain_oe", cipo_oe, 0);
        check_counts("mis13");
        cs_end();

        exp_err++;
        wr_frame(8'h04, 8'd8, 32'h11, 2);
        exp_err++;
        wr_frame(8'h03, 8'd8, 32'h11223344, 8);
        exp_err++;
        wr_frame(8'h82, 8'h72, 32'h0, 8);
        check_counts("bad");

        // write aborted after 5 of 8 data nibbles
        cs_start();
        send_byte(8'h02);
        send_byte(8'h20);
        for (int i = 0; i < 5; i++) nib(4'h9);
        CS_N = 1'b1;
        #80;
        check_counts("abort");
        exp_write(8'd2, 32'h005A0000, 4'b0100);
        wr_frame(8'h00, 8'd2, 32'h5A, 2);
        check_counts("after_abort");

        // reset in the middle of read data
        rq.push_back(8'h40);
        exp_re++;
        rd_value = 32'hCAFEF00D;
        nq.push_back(4'h0);
        nq.push_back(4'h0);
        nq.push_back(4'hC);
        nq.push_back(4'hA);
        cs_start();
        send_byte(8'h82);
        send_byte(8'h40);
        for (int i = 0; i < 4; i++) nib_rd();
        #30 rst_n = 1'b0;
        #1;
        check("rstmid_cipo", CIPO, 0);
        check("rstmid_oe", cipo_oe, 0);
        #9 CS_N = 1'b1;
        #40 rst_n = 1'b1;
        #50;
        exp_write(8'd1, 32'h00000100, 4'b0010);
        wr_frame(8'h00, 8'd1, 32'h01, 2);

        #100;
        check_counts("final");
        check("both_strobes", both_seen, 0);
        check("wq_left", wq.size(), 0);
        check("rq_left", rq.size(), 0);
        check("nq_left", nq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/qspi_target.md
Name: qspi_target

Overview:
- Quad-SPI responder that sits between the chip pads (CS_N/SCK/COPI/CIPO) and the digital_top register file.
- Decodes byte/halfword/word read and write frames from an external initiator.
- Issues single-cycle register-file write or read strobes in the clk domain.
- Serialises read data back on CIPO.

Parameters:
AWIDTH, 8, byte-address width carried in the frame
DWIDTH, 32, register-file data width (fixed at 32; 4 byte lanes)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
CS_N  input  1  chip select, active low, asynchronous to clk
SCK  input  1  SPI clock, mode 0, asynchronous to clk
COPI  input  4  quad data from initiator
CIPO  output  4  quad data to initiator
cipo_oe  output  1  pad output enable for CIPO
reg_addr  output  AWIDTH  byte address, aligned to access size
reg_wdata  output  32  write data, lane-aligned
reg_be  output  4  byte enables
reg_we  output  1  one-cycle write strobe
reg_re  output  1  one-cycle read strobe
reg_rdata  input  32  read data, valid the cycle after reg_re
frame_err  output  1  one-cycle pulse on misaligned or unknown command

Behaviour:
- Reset values: CIPO=0, cipo_oe=0, reg_* = 0, frame_err=0. FSM state is IDLE.
- Synchronisation:
  - CS_N, SCK and COPI each pass through 2-flop synchronisers.
  - SCK rise/fall are detected from the synchronised value.
  - Requirement: f_SCK <= f_clk/4.
- Framing:
  - Every SCK rise samples one COPI nibble, MSB nibble first.
  - Byte 0 is the command byte:
    - bit7 = 1 for read, 0 for write.
    - bits[1:0] give the size: 0 = byte, 1 = halfword, 2 = word.
    - bits[6:2] must be 0.
  - Byte 1 is the byte address.
- Data bytes:
  - Data are sent most-significant byte first.
  - N bytes per access: 1, 2 or 4.
- FSM states:
  - IDLE: waits for CS_N to fall, then goes to CMD.
  - CMD: 2 nibbles, then goes to ADDR.
  - ADDR: 2 nibbles, then validates the frame.
  - Invalid frame (size=3, nonzero bits[6:2], halfword with addr[0]=1, or word with addr[1:0]!=0):
    - Pulse frame_err.
    - Go to DRAIN.
  - Valid write: go to WDATA.
  - Valid read: go to RTURN.
  - WDATA: takes 2N nibbles. After the final nibble:
    - Assert reg_we for exactly one clk.
    - reg_addr = addr with low bits masked to the access size.
    - reg_be = the lanes selected by addr[1:0] and size.
    - reg_wdata = the data placed in those lanes, other lanes 0.
    - Then go to DRAIN.
  - RTURN:
    - reg_re is pulsed one clk after ADDR completes.
    - reg_rdata is captured on the following clk.
    - The turnaround lasts 2 SCK periods (one dummy byte), during which CIPO=0 and cipo_oe=1.
  - RDATA:
    - Presents the selected lanes, 2N nibbles, MSB first.
    - Each nibble is updated on SCK fall so the initiator samples it on rise.
    - The first data nibble is driven on the fall that ends the dummy byte.
    - After the last nibble, go to DRAIN.
  - DRAIN:
    - Ignores further SCK.
    - cipo_oe=0.
    - Stays until CS_N rises.
- CS_N rising in any state:
  - Returns to IDLE within 3 clk.
  - cipo_oe=0.
  - A partially received write is discarded: no reg_we.
  - A read already strobed is not cancelled.
- Extra nibbles beyond the frame length are ignored. Back-to-back frames need CS_N high for >= 2 clk.
- reg_we and reg_re are never asserted in the same cycle, and each is asserted at most once per frame.
- Asynchronous reset mid-frame forces IDLE immediately. The initiator must re-drive CS_N high then low before a new frame.

Test Plan:
- Write halfword, cmd 0x01, addr 12, data 0x000B:
  - one reg_we.
  - reg_addr=12, reg_be=4'b0011, reg_wdata=0x0000000B.
  - frame_err=0.
- Write halfword, addr 14, data 0x0315 (789):
  - reg_be=4'b1100, reg_wdata=0x03150000.
- Write word, addr 112, data 0x00AAAAAA, then read word 112 with reg_rdata returning 0x00AAAAAA:
  - reg_re pulses once.
  - CIPO emits nibbles 0,0,A,A,A,A,A,A after the dummy byte.
  - cipo_oe drops after CS_N rises.
- Read byte, addr 0, reg_rdata=0x00000055: CIPO emits 5,5.
- Read byte, addr 3, reg_rdata=0x77000000: CIPO emits 7,7.
- Halfword write to addr 13: frame_err pulses, no reg_we, FSM stays in DRAIN until CS_N rises.
- Word write with CS_N raised after 5 of 8 data nibbles: no reg_we; the next valid frame completes normally.
- Reset asserted during RDATA:
  - CIPO=0, cipo_oe=0, FSM in IDLE.
  - A following byte write to addr 1 (data 0x01) produces reg_be=4'b0010, reg_wdata=0x00000100.
